// File: rtl/cu_pkg.sv
// cu_pkg: shared definitions for control_unit_v2.
//   - 5-bit opcode constants decoded from the top of IR
//   - state_t: 7-bit micro-step encoding (S_RST = 0), also driven on the debug port
//   - strobes_t: bundle of every datapath strobe, in the same order as the
//     top-level strobe ports so it can be unpacked with one concatenation
package cu_pkg;

    localparam logic [4:0] OP_LD   = 5'b00000;
    localparam logic [4:0] OP_LDI  = 5'b00001;
    localparam logic [4:0] OP_ST   = 5'b00010;
    localparam logic [4:0] OP_ADD  = 5'b00011;
    localparam logic [4:0] OP_SUB  = 5'b00100;
    localparam logic [4:0] OP_SHR  = 5'b00101;
    localparam logic [4:0] OP_SHRA = 5'b00110;
    localparam logic [4:0] OP_SHL  = 5'b00111;
    localparam logic [4:0] OP_ROR  = 5'b01000;
    localparam logic [4:0] OP_ROL  = 5'b01001;
    localparam logic [4:0] OP_AND  = 5'b01010;
    localparam logic [4:0] OP_OR   = 5'b01011;
    localparam logic [4:0] OP_ADDI = 5'b01100;
    localparam logic [4:0] OP_ANDI = 5'b01101;
    localparam logic [4:0] OP_ORI  = 5'b01110;
    localparam logic [4:0] OP_MUL  = 5'b01111;
    localparam logic [4:0] OP_DIV  = 5'b10000;
    localparam logic [4:0] OP_NEG  = 5'b10001;
    localparam logic [4:0] OP_NOT  = 5'b10010;
    localparam logic [4:0] OP_BR   = 5'b10011;
    localparam logic [4:0] OP_JR   = 5'b10100;
    localparam logic [4:0] OP_JAL  = 5'b10101;
    localparam logic [4:0] OP_IN   = 5'b10110;
    localparam logic [4:0] OP_OUT  = 5'b10111;
    localparam logic [4:0] OP_MFHI = 5'b11000;
    localparam logic [4:0] OP_MFLO = 5'b11001;
    localparam logic [4:0] OP_NOP  = 5'b11010;
    localparam logic [4:0] OP_HALT = 5'b11011;

    typedef enum logic [6:0] {
        S_RST = 7'd0,
        S_F0, S_F1, S_F1W, S_F2, S_DEC,
        S_A3, S_A4, S_A5,
        S_I3, S_I4, S_I5,
        S_M3, S_M4, S_M5, S_M6,
        S_U3, S_U4,
        S_L3, S_L4, S_L5, S_L6W, S_L7, S_LI5,
        S_S6, S_S7W,
        S_B3, S_B4, S_B5, S_B6,
        S_JR3, S_J3, S_J4,
        S_IN3, S_OUT3, S_MH3, S_ML3, S_NOP3,
        S_HALT, S_FAULT
    } state_t;

    typedef struct packed {
        logic PCout;
        logic Zhighout;
        logic Zlowout;
        logic MDRout;
        logic MARin;
        logic PCin;
        logic MDRin;
        logic IRin;
        logic Yin;
        logic IncPC;
        logic Read;
        logic HIin;
        logic LOin;
        logic HIout;
        logic LOout;
        logic Zin;
        logic Cout;
        logic Write;
        logic Gra;
        logic Grb;
        logic Grc;
        logic Rin;
        logic Rout;
        logic BAout;
        logic CONin;
        logic InPortin;
        logic OutPortin;
        logic InPortout;
    } strobes_t;

endpackage

// File: rtl/control_unit_v2.sv
// control_unit_v2: multi-cycle control sequencer. Decodes IR's opcode and
// steps through one micro-state per clock, driving datapath strobes as Moore
// outputs (function of the present state only).
// Ports:
//   clock, clear            rising-edge clock, synchronous active-high reset
//   IR[IR_W-1:0]            current instruction, opcode = IR[IR_W-1 -: 5]
//   stop                    halt request, honoured at the next instruction end
//   con_ff                  branch condition, sampled in B4
//   mem_ready               memory handshake (see below)
//   PCout .. InPortout      datapath strobes
//   Run, fault              running flag / sticky fault flag
//   state[6:0]              present state, for debug
// Memory handshake: a wait state (F1W, L6W, S7W) holds its Read/Write strobe
// and waits; a cycle with mem_ready=1 completes the transfer and the state
// advances at the following edge. After WAIT_LIMIT cycles without mem_ready
// the sequencer traps in FAULT. mem_ready outside wait states is ignored.
module control_unit_v2
    import cu_pkg::*;
#(
    parameter int IR_W       = 32,
    parameter int WAIT_LIMIT = 15
) (
    input  logic            clock,
    input  logic            clear,
    input  logic [IR_W-1:0] IR,
    input  logic            stop,
    input  logic            con_ff,
    input  logic            mem_ready,
    output logic            PCout, Zhighout, Zlowout, MDRout, MARin, PCin, MDRin,
    output logic            IRin, Yin, IncPC, Read, HIin, LOin, HIout, LOout,
    output logic            Zin, Cout, Write, Gra, Grb, Grc, Rin, Rout, BAout,
    output logic            CONin, InPortin, OutPortin, InPortout,
    output logic            Run,
    output logic            fault,
    output logic [6:0]      state
);

    localparam logic [7:0] LIMIT_M1 = 8'(WAIT_LIMIT - 1);

    state_t     cur, nxt, end_nxt;
    logic [7:0] wait_cnt;
    logic       stop_pend;
    logic       in_wait, timeout;
    logic [4:0] opcode;
    strobes_t   sb;
    logic       run_c, fault_c;
    logic       unused_ir;

    assign opcode    = IR[IR_W-1 -: 5];
    assign unused_ir = ^IR[IR_W-6:0];
    assign in_wait   = (cur == S_F1W) || (cur == S_L6W) || (cur == S_S7W);
    // This is the WAIT_LIMIT-th consecutive cycle without mem_ready.
    assign timeout   = !mem_ready && (wait_cnt >= LIMIT_M1);
    // Where every instruction goes once its last micro-step is done.
    assign end_nxt   = stop_pend ? S_HALT : S_F0;

    always_ff @(posedge clock) begin
        if (clear) begin
            cur       <= S_RST;
            wait_cnt  <= '0;
            stop_pend <= 1'b0;
        end else begin
            cur       <= nxt;
            stop_pend <= stop_pend | stop;
            // Wait states are never back to back, so the count is zero on entry.
            if (in_wait && !mem_ready) wait_cnt <= wait_cnt + 8'd1;
            else                       wait_cnt <= '0;
        end
    end

    always_comb begin
        nxt = cur;
        case (cur)
            S_RST:  nxt = S_F0;
            S_F0:   nxt = S_F1;
            S_F1:   nxt = S_F1W;
            S_F1W:  nxt = mem_ready ? S_F2 : (timeout ? S_FAULT : S_F1W);
            S_F2:   nxt = S_DEC;
            S_DEC: begin
                case (opcode)
                    OP_LD, OP_LDI, OP_ST:                    nxt = S_L3;
                    OP_ADD, OP_SUB, OP_SHR, OP_SHRA, OP_SHL,
                    OP_ROR, OP_ROL, OP_AND, OP_OR:           nxt = S_A3;
                    OP_ADDI, OP_ANDI, OP_ORI:                nxt = S_I3;
                    OP_MUL, OP_DIV:                          nxt = S_M3;
                    OP_NEG, OP_NOT:                          nxt = S_U3;
                    OP_BR:                                   nxt = S_B3;
                    OP_JR:                                   nxt = S_JR3;
                    OP_JAL:                                  nxt = S_J3;
                    OP_IN:                                   nxt = S_IN3;
                    OP_OUT:                                  nxt = S_OUT3;
                    OP_MFHI:                                 nxt = S_MH3;
                    OP_MFLO:                                 nxt = S_ML3;
                    OP_NOP:                                  nxt = S_NOP3;
                    OP_HALT:                                 nxt = S_HALT;
                    default:                                 nxt = S_FAULT;
                endcase
            end
            S_A3:   nxt = S_A4;
            S_A4:   nxt = S_A5;
            S_I3:   nxt = S_I4;
            S_I4:   nxt = S_I5;
            S_M3:   nxt = S_M4;
            S_M4:   nxt = S_M5;
            S_M5:   nxt = S_M6;
            S_U3:   nxt = S_U4;
            S_L3:   nxt = S_L4;
            // ld/ldi/st share L3-L4; they split by opcode from here on.
            S_L4:   nxt = (opcode == OP_LDI) ? S_LI5 : S_L5;
            S_L5:   nxt = (opcode == OP_ST) ? S_S6 : S_L6W;
            S_L6W:  nxt = mem_ready ? S_L7 : (timeout ? S_FAULT : S_L6W);
            S_S6:   nxt = S_S7W;
            S_S7W:  nxt = mem_ready ? end_nxt : (timeout ? S_FAULT : S_S7W);
            S_B3:   nxt = S_B4;
            // Not-taken branches skip the target computation entirely.
            S_B4:   nxt = con_ff ? S_B5 : end_nxt;
            S_B5:   nxt = S_B6;
            S_J3:   nxt = S_J4;
            S_A5, S_I5, S_M6, S_U4, S_L7, S_LI5, S_B6, S_JR3, S_J4,
            S_IN3, S_OUT3, S_MH3, S_ML3, S_NOP3:
                    nxt = end_nxt;
            S_HALT:  nxt = S_HALT;
            S_FAULT: nxt = S_FAULT;
            default: nxt = S_FAULT;
        endcase
    end

    always_comb begin
        sb      = '0;
        run_c   = 1'b1;
        fault_c = 1'b0;
        case (cur)
            S_F0:   begin sb.PCout = 1'b1; sb.MARin = 1'b1; sb.IncPC = 1'b1; sb.Zin = 1'b1; end
            S_F1:   begin sb.Zlowout = 1'b1; sb.PCin = 1'b1; end
            S_F1W:  begin sb.Read = 1'b1; sb.MDRin = 1'b1; end
            S_F2:   begin sb.MDRout = 1'b1; sb.IRin = 1'b1; end
            S_A3, S_I3: begin sb.Grb = 1'b1; sb.Rout = 1'b1; sb.Yin = 1'b1; end
            S_A4:   begin sb.Grc = 1'b1; sb.Rout = 1'b1; sb.Zin = 1'b1; end
            S_A5, S_I5, S_U4, S_LI5:
                    begin sb.Gra = 1'b1; sb.Rin = 1'b1; sb.Zlowout = 1'b1; end
            S_I4, S_L4, S_B5: begin sb.Cout = 1'b1; sb.Zin = 1'b1; end
            S_M3:   begin sb.Gra = 1'b1; sb.Rout = 1'b1; sb.Yin = 1'b1; end
            S_M4, S_U3: begin sb.Grb = 1'b1; sb.Rout = 1'b1; sb.Zin = 1'b1; end
            S_M5:   begin sb.LOin = 1'b1; sb.Zlowout = 1'b1; end
            S_M6:   begin sb.HIin = 1'b1; sb.Zhighout = 1'b1; end
            S_L3:   begin sb.Grb = 1'b1; sb.BAout = 1'b1; sb.Yin = 1'b1; end
            S_L5:   begin sb.MARin = 1'b1; sb.Zlowout = 1'b1; end
            S_L6W:  begin sb.Read = 1'b1; sb.MDRin = 1'b1; end
            S_L7:   begin sb.MDRout = 1'b1; sb.Gra = 1'b1; sb.Rin = 1'b1; end
            S_S6:   begin sb.Gra = 1'b1; sb.Rout = 1'b1; sb.MDRin = 1'b1; end
            S_S7W:  sb.Write = 1'b1;
            S_B3:   begin sb.Gra = 1'b1; sb.Rout = 1'b1; sb.CONin = 1'b1; end
            S_B4:   begin sb.PCout = 1'b1; sb.Yin = 1'b1; end
            S_B6:   begin sb.PCin = 1'b1; sb.Zlowout = 1'b1; end
            S_JR3, S_J4: begin sb.Gra = 1'b1; sb.Rout = 1'b1; sb.PCin = 1'b1; end
            S_J3:   begin sb.Grb = 1'b1; sb.Rin = 1'b1; sb.PCout = 1'b1; end
            S_IN3:  begin sb.Gra = 1'b1; sb.Rin = 1'b1; sb.InPortout = 1'b1; end
            S_OUT3: begin sb.Gra = 1'b1; sb.Rout = 1'b1; sb.OutPortin = 1'b1; end
            S_MH3:  begin sb.Gra = 1'b1; sb.Rin = 1'b1; sb.HIout = 1'b1; end
            S_ML3:  begin sb.Gra = 1'b1; sb.Rin = 1'b1; sb.LOout = 1'b1; end
            S_HALT: run_c = 1'b0;
            S_FAULT: begin run_c = 1'b0; fault_c = 1'b1; end
            default: ;
        endcase
    end

    assign {PCout, Zhighout, Zlowout, MDRout, MARin, PCin, MDRin, IRin, Yin,
            IncPC, Read, HIin, LOin, HIout, LOout, Zin, Cout, Write, Gra, Grb,
            Grc, Rin, Rout, BAout, CONin, InPortin, OutPortin, InPortout} = sb;
    assign Run   = run_c;
    assign fault = fault_c;
    assign state = cur;

endmodule

// File: tb/tb_control_unit_v2.sv
// Bench for control_unit_v2: a micro-program model builds, per instruction,
// the expected per-cycle output vector plus the inputs to drive in that
// cycle; the runner replays it against the DUT and compares every cycle.
module tb_control_unit_v2;
    localparam int IR_W = 32;
    localparam int WL   = 4;

    // Strobe bit positions in the bench's own output vector.
    localparam logic [27:0] M_PCOUT     = 28'd1 << 0;
    localparam logic [27:0] M_ZHIGHOUT  = 28'd1 << 1;
    localparam logic [27:0] M_ZLOWOUT   = 28'd1 << 2;
    localparam logic [27:0] M_MDROUT    = 28'd1 << 3;
    localparam logic [27:0] M_MARIN     = 28'd1 << 4;
    localparam logic [27:0] M_PCIN      = 28'd1 << 5;
    localparam logic [27:0] M_MDRIN     = 28'd1 << 6;
    localparam logic [27:0] M_IRIN      = 28'd1 << 7;
    localparam logic [27:0] M_YIN       = 28'd1 << 8;
    localparam logic [27:0] M_INCPC     = 28'd1 << 9;
    localparam logic [27:0] M_READ      = 28'd1 << 10;
    localparam logic [27:0] M_HIIN      = 28'd1 << 11;
    localparam logic [27:0] M_LOIN      = 28'd1 << 12;
    localparam logic [27:0] M_HIOUT     = 28'd1 << 13;
    localparam logic [27:0] M_LOOUT     = 28'd1 << 14;
    localparam logic [27:0] M_ZIN       = 28'd1 << 15;
    localparam logic [27:0] M_COUT      = 28'd1 << 16;
    localparam logic [27:0] M_WRITE     = 28'd1 << 17;
    localparam logic [27:0] M_GRA       = 28'd1 << 18;
    localparam logic [27:0] M_GRB       = 28'd1 << 19;
    localparam logic [27:0] M_GRC       = 28'd1 << 20;
    localparam logic [27:0] M_RIN       = 28'd1 << 21;
    localparam logic [27:0] M_ROUT      = 28'd1 << 22;
    localparam logic [27:0] M_BAOUT     = 28'd1 << 23;
    localparam logic [27:0] M_CONIN     = 28'd1 << 24;
    localparam logic [27:0] M_OUTPORTIN = 28'd1 << 26;
    localparam logic [27:0] M_INPORTOUT = 28'd1 << 27;

    logic clock = 1'b0;
    logic clear, stop, con_ff, mem_ready;
    logic [IR_W-1:0] IR;
    logic PCout, Zhighout, Zlowout, MDRout, MARin, PCin, MDRin, IRin, Yin;
    logic IncPC, Read, HIin, LOin, HIout, LOout, Zin, Cout, Write, Gra, Grb;
    logic Grc, Rin, Rout, BAout, CONin, InPortin, OutPortin, InPortout;
    logic Run, fault;
    logic [6:0] state;
    logic [29:0] dut_vec;

    always #5 clock = ~clock;

    control_unit_v2 #(.IR_W(IR_W), .WAIT_LIMIT(WL)) dut (
        .clock(clock), .clear(clear), .IR(IR), .stop(stop), .con_ff(con_ff),
        .mem_ready(mem_ready),
        .PCout(PCout), .Zhighout(Zhighout), .Zlowout(Zlowout), .MDRout(MDRout),
        .MARin(MARin), .PCin(PCin), .MDRin(MDRin), .IRin(IRin), .Yin(Yin),
        .IncPC(IncPC), .Read(Read), .HIin(HIin), .LOin(LOin), .HIout(HIout),
        .LOout(LOout), .Zin(Zin), .Cout(Cout), .Write(Write), .Gra(Gra),
        .Grb(Grb), .Grc(Grc), .Rin(Rin), .Rout(Rout), .BAout(BAout),
        .CONin(CONin), .InPortin(InPortin), .OutPortin(OutPortin),
        .InPortout(InPortout), .Run(Run), .fault(fault), .state(state)
    );

    assign dut_vec = {fault, Run, InPortout, OutPortin, InPortin, CONin, BAout,
                      Rout, Rin, Grc, Grb, Gra, Write, Cout, Zin, LOout, HIout,
                      LOin, HIin, Read, IncPC, Yin, IRin, MDRin, PCin, MARin,
                      MDRout, Zlowout, Zhighout, PCout};

    // Scoreboard: expected vector, inputs for that cycle {stop, con_ff, mem_ready}, step name.
    logic [29:0] exp_q[$];
    logic [2:0]  drv_q[$];
    string       tag_q[$];

    int n_pass, n_checks;
    int idx, stop_at_g;
    bit pend, last_pend, term;

    task automatic check(input string tag, input logic [29:0] got, input logic [29:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    endtask

    // ---------------- reference model ----------------
    task automatic push_full(input string name, input logic [29:0] e, input int mr, input int cf);
        bit st, mrb, cfb;
        st  = (idx == stop_at_g);
        mrb = (mr < 0) ? 1'($urandom_range(0, 1)) : 1'(mr);
        cfb = (cf < 0) ? 1'($urandom_range(0, 1)) : 1'(cf);
        exp_q.push_back(e);
        drv_q.push_back({st, cfb, mrb});
        tag_q.push_back(name);
        last_pend = pend;   // decision at this step sees only earlier stops
        pend = pend | st;
        idx++;
    endtask

    task automatic push(input string name, input logic [27:0] m);
        push_full(name, {2'b01, m}, -1, -1);
    endtask

    task automatic terminal_halt();
        for (int i = 0; i < 20; i++) push_full("HALT", 30'd0, -1, -1);
        term = 1'b1;
    endtask

    task automatic terminal_fault();
        for (int i = 0; i < 4; i++) push_full("FAULT", {2'b10, 28'd0}, -1, -1);
        term = 1'b1;
    endtask

    task automatic finish_instr();
        if (last_pend) terminal_halt();
    endtask

    // nw = cycles with mem_ready low before the ready cycle; returns 1 on timeout.
    task automatic wait_phase(input string name, input logic [27:0] m, input int nw, output bit flt);
        if (nw >= WL) begin
            for (int i = 0; i < WL; i++) push_full(name, {2'b01, m}, 0, -1);
            flt = 1'b1;
        end else begin
            for (int i = 0; i < nw; i++) push_full(name, {2'b01, m}, 0, -1);
            push_full(name, {2'b01, m}, 1, -1);
            flt = 1'b0;
        end
    endtask

    task automatic gen_instr(input int op, input bit cf, input int nwf, input int nwm, input int stop_at);
        bit flt;
        idx = 0;
        stop_at_g = stop_at;
        push("F0", M_PCOUT | M_MARIN | M_INCPC | M_ZIN);
        push("F1", M_ZLOWOUT | M_PCIN);
        wait_phase("F1W", M_READ | M_MDRIN, nwf, flt);
        if (flt) begin terminal_fault(); return; end
        push("F2", M_MDROUT | M_IRIN);
        push("DEC", 28'd0);
        if (op >= 3 && op <= 11) begin
            push("A3", M_GRB | M_ROUT | M_YIN);
            push("A4", M_GRC | M_ROUT | M_ZIN);
            push("A5", M_GRA | M_RIN | M_ZLOWOUT);
            finish_instr();
        end else if (op >= 12 && op <= 14) begin
            push("I3", M_GRB | M_ROUT | M_YIN);
            push("I4", M_COUT | M_ZIN);
            push("I5", M_GRA | M_RIN | M_ZLOWOUT);
            finish_instr();
        end else if (op == 15 || op == 16) begin
            push("M3", M_GRA | M_ROUT | M_YIN);
            push("M4", M_GRB | M_ROUT | M_ZIN);
            push("M5", M_LOIN | M_ZLOWOUT);
            push("M6", M_HIIN | M_ZHIGHOUT);
            finish_instr();
        end else if (op == 17 || op == 18) begin
            push("U3", M_GRB | M_ROUT | M_ZIN);
            push("U4", M_GRA | M_RIN | M_ZLOWOUT);
            finish_instr();
        end else if (op <= 2) begin
            push("L3", M_GRB | M_BAOUT | M_YIN);
            push("L4", M_COUT | M_ZIN);
            if (op == 1) begin
                push("LI5", M_GRA | M_RIN | M_ZLOWOUT);
                finish_instr();
                return;
            end
            push("L5", M_MARIN | M_ZLOWOUT);
            if (op == 0) begin
                wait_phase("L6W", M_READ | M_MDRIN, nwm, flt);
                if (flt) begin terminal_fault(); return; end
                push("L7", M_MDROUT | M_GRA | M_RIN);
            end else begin
                push("S6", M_GRA | M_ROUT | M_MDRIN);
                wait_phase("S7W", M_WRITE, nwm, flt);
                if (flt) begin terminal_fault(); return; end
            end
            finish_instr();
        end else if (op == 19) begin
            push("B3", M_GRA | M_ROUT | M_CONIN);
            push_full("B4", {2'b01, M_PCOUT | M_YIN}, -1, int'(cf));
            if (cf) begin
                push("B5", M_COUT | M_ZIN);
                push("B6", M_PCIN | M_ZLOWOUT);
            end
            finish_instr();
        end else if (op >= 20 && op <= 26) begin
            case (op)
                20: push("JR3", M_GRA | M_ROUT | M_PCIN);
                21: begin
                    push("J3", M_GRB | M_RIN | M_PCOUT);
                    push("J4", M_GRA | M_ROUT | M_PCIN);
                end
                22: push("IN3", M_GRA | M_RIN | M_INPORTOUT);
                23: push("OUT3", M_GRA | M_ROUT | M_OUTPORTIN);
                24: push("MH3", M_GRA | M_RIN | M_HIOUT);
                25: push("ML3", M_GRA | M_RIN | M_LOOUT);
                default: push("NOP3", 28'd0);
            endcase
            finish_instr();
        end else if (op == 27) begin
            terminal_halt();
        end else begin
            terminal_fault();
        end
    endtask

    // ---------------- drivers ----------------
    task automatic do_reset();
        clear = 1'b1;
        stop = 1'b1;                       // must be ignored while clear is high
        mem_ready = 1'($urandom_range(0, 1));
        @(posedge clock);
        @(negedge clock);
        check("rst_vec", dut_vec, {2'b01, 28'd0});
        @(posedge clock);
        #1 clear = 1'b0;
        stop = 1'b0;
        @(negedge clock);
        check("rst_vec2", dut_vec, {2'b01, 28'd0});
        check("rst_state", {23'd0, state}, 30'd0);
        pend = 1'b0;
        last_pend = 1'b0;
        term = 1'b0;
    endtask

    task automatic run_q(input string stop_tag);
        logic [29:0] e;
        logic [2:0]  d;
        string       t;
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            d = drv_q.pop_front();
            t = tag_q.pop_front();
            @(posedge clock);
            #1;
            mem_ready = d[0];
            con_ff    = d[1];
            stop      = d[2];
            @(negedge clock);
            check(t, dut_vec, e);
            if (stop_tag != "" && t == stop_tag) begin
                exp_q.delete();
                drv_q.delete();
                tag_q.delete();
            end
        end
        stop = 1'b0;
    endtask

    task automatic run_ir(input logic [31:0] ir, input bit cf, input int nwf, input int nwm, input int stop_at);
        IR = ir;
        gen_instr(int'(ir[31:27]), cf, nwf, nwm, stop_at);
        run_q("");
        if (term) do_reset();
    endtask

    task automatic run_op(input int op, input bit cf, input int nwf, input int nwm, input int stop_at);
        logic [31:0] r;
        r = $urandom;
        run_ir({5'(op), r[26:0]}, cf, nwf, nwm, stop_at);
    endtask

    initial begin
        n_pass = 0;
        n_checks = 0;
        clear = 1'b1;
        stop = 1'b0;
        con_ff = 1'b0;
        mem_ready = 1'b0;
        IR = '0;
        pend = 1'b0;
        last_pend = 1'b0;
        term = 1'b0;
        do_reset();

        run_ir(32'h1800_0000, 1'b0, 0, 0, -1);  // add, 8 cycles
        run_op(0, 1'b0, 0, 3, -1);              // ld with 3 memory waits
        run_op(3, 1'b0, 6, 0, -1);              // fetch timeout -> FAULT
        run_op(19, 1'b0, 0, 0, -1);             // br not taken
        run_op(19, 1'b1, 0, 0, -1);             // br taken
        run_op(3, 1'b0, 0, 0, 6);               // stop during A4 -> HALT
        run_op(30, 1'b0, 0, 0, -1);             // illegal opcode
        run_op(1, 1'b0, 1, 0, -1);              // ldi
        run_op(2, 1'b0, 0, 5, -1);              // st timeout in S7W

        // clear during S7W: RST next cycle, Write dropped
        IR = {5'd2, 27'h0};
        gen_instr(2, 1'b0, 0, 2, -1);
        run_q("S7W");
        do_reset();

        for (int n = 0; n < 80; n++) begin
            int op, nwf, nwm, sa;
            op  = ($urandom_range(0, 19) == 0) ? int'($urandom_range(27, 31)) : int'($urandom_range(0, 26));
            nwf = ($urandom_range(0, 9) == 0) ? 5 : int'($urandom_range(0, 2));
            nwm = ($urandom_range(0, 9) == 0) ? 5 : int'($urandom_range(0, 2));
            sa  = ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, 11)) : -1;
            run_op(op, 1'($urandom_range(0, 1)), nwf, nwm, sa);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
